// File: rtl/multi_pixel_filter.sv
// 3x3 neighbourhood filter. It applies one selectable kernel to each 8-bit
// channel on its own and registers the result with a single-cycle latency.
// The only state in the block is the output register.
module multi_pixel_filter #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] window_0,
  input  logic [DATA_WIDTH-1:0] window_1,
  input  logic [DATA_WIDTH-1:0] window_2,
  input  logic [DATA_WIDTH-1:0] window_3,
  input  logic [DATA_WIDTH-1:0] window_4,
  input  logic [DATA_WIDTH-1:0] window_5,
  input  logic [DATA_WIDTH-1:0] window_6,
  input  logic [DATA_WIDTH-1:0] window_7,
  input  logic [DATA_WIDTH-1:0] window_8,
  input  logic [3:0]            sw,
  output logic [DATA_WIDTH-1:0] output_1
);

  localparam int NUM_CH = DATA_WIDTH / 8;

  localparam logic [3:0] SW_BOX    = 4'b0100;
  localparam logic [3:0] SW_SOBELX = 4'b0101;
  localparam logic [3:0] SW_CENTRE = 4'b0110;
  localparam logic [3:0] SW_HDIFF  = 4'b0111;
  localparam logic [3:0] SW_GAUSS  = 4'b1100;

  logic [DATA_WIDTH-1:0] win [9];
  logic [DATA_WIDTH-1:0] output_next;

  assign win[0] = window_0;
  assign win[1] = window_1;
  assign win[2] = window_2;
  assign win[3] = window_3;
  assign win[4] = window_4;
  assign win[5] = window_5;
  assign win[6] = window_6;
  assign win[7] = window_7;
  assign win[8] = window_8;

  // One identical datapath per channel. The sums are 12 bits wide so they
  // never wrap, and every reduction back to 8 bits is an explicit shift or
  // a divide.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      logic [7:0]         p [9];
      logic [11:0]        box_sum;
      logic [11:0]        gauss_sum;
      logic [11:0]        sobel_pos;
      logic [11:0]        sobel_neg;
      logic signed [11:0] sobel_diff;
      logic [11:0]        sobel_mag;
      logic [7:0]         hdiff;
      logic [7:0]         chan_next;

      // Pull this channel's byte out of each window position.
      always_comb begin
        for (int k = 0; k < 9; k++) begin
          p[k] = win[k][gi*8 +: 8];
        end
      end

      // Kernel arithmetic. All kernels are computed in parallel, and the
      // selected one is muxed afterwards.
      always_comb begin
        box_sum = 12'd0;
        for (int k = 0; k < 9; k++) begin
          box_sum = box_sum + {4'd0, p[k]};
        end

        gauss_sum = {4'd0, p[0]} + {3'd0, p[1], 1'b0} + {4'd0, p[2]}
                  + {3'd0, p[3], 1'b0} + {2'd0, p[4], 2'b0} + {3'd0, p[5], 1'b0}
                  + {4'd0, p[6]} + {3'd0, p[7], 1'b0} + {4'd0, p[8]};

        // Left column minus right column, with the middle row weighted by 2.
        sobel_pos  = {4'd0, p[0]} + {3'd0, p[3], 1'b0} + {4'd0, p[6]};
        sobel_neg  = {4'd0, p[2]} + {3'd0, p[5], 1'b0} + {4'd0, p[8]};
        sobel_diff = $signed(sobel_pos) - $signed(sobel_neg);
        sobel_mag  = sobel_diff[11] ? 12'(-sobel_diff) : 12'(sobel_diff);

        hdiff = (p[6] >= p[8]) ? (p[6] - p[8]) : (p[8] - p[6]);
      end

      // Kernel select. Any unlisted code passes the centre pixel through.
      always_comb begin
        chan_next = p[4];
        case (sw)
          SW_BOX:    chan_next = 8'(box_sum / 12'd9);
          SW_SOBELX: chan_next = 8'(sobel_mag >> 2);
          SW_CENTRE: chan_next = p[4];
          SW_HDIFF:  chan_next = hdiff;
          SW_GAUSS:  chan_next = 8'(gauss_sum >> 4);
          default:   chan_next = p[4];
        endcase
      end

      assign output_next[gi*8 +: 8] = chan_next;
    end
  endgenerate

  // Output register. A synchronous reset loads zero, whatever the inputs are.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      output_1 <= '0;
    end else begin
      output_1 <= output_next;
    end
  end

endmodule

// File: tb/tb_multi_pixel_filter.sv
module tb_multi_pixel_filter;

  logic        clk;
  logic        n_rst;
  logic [23:0] win [9];
  logic [3:0]  sw;
  logic [23:0] output_1;

  int total;
  int bad;
  int txn;

  multi_pixel_filter #(.DATA_WIDTH(24)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .window_0 (win[0]),
    .window_1 (win[1]),
    .window_2 (win[2]),
    .window_3 (win[3]),
    .window_4 (win[4]),
    .window_5 (win[5]),
    .window_6 (win[6]),
    .window_7 (win[7]),
    .window_8 (win[8]),
    .sw       (sw),
    .output_1 (output_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It works on plain integers per channel and follows the
  // kernel definitions directly.
  function automatic logic [23:0] model(input logic [23:0] w [9], input logic [3:0] s);
    logic [23:0] r;
    int v [9];
    int acc;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 9; k++) v[k] = int'(w[k][c*8 +: 8]);
      case (s)
        4'b0100: begin
          acc = 0;
          for (int k = 0; k < 9; k++) acc += v[k];
          acc = acc / 9;
        end
        4'b0101: begin
          acc = (v[0] + 2*v[3] + v[6]) - (v[2] + 2*v[5] + v[8]);
          if (acc < 0) acc = -acc;
          acc = acc / 4;
        end
        4'b0111: begin
          acc = v[6] - v[8];
          if (acc < 0) acc = -acc;
        end
        4'b1100: acc = (v[0] + 2*v[1] + v[2] + 2*v[3] + 4*v[4] + 2*v[5]
                        + v[6] + 2*v[7] + v[8]) / 16;
        default: acc = v[4];
      endcase
      r[c*8 +: 8] = 8'(acc);
    end
    return r;
  endfunction

  task automatic clear_windows();
    for (int k = 0; k < 9; k++) win[k] = 24'h0;
  endtask

  task automatic random_windows();
    for (int k = 0; k < 9; k++) win[k] = 24'($urandom);
  endtask

  // While reset is held, the output must read zero for any inputs and any kernel.
  task automatic test_reset();
    logic [23:0] exp;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random_windows();
      sw = 4'($urandom);
      @(posedge clk); #1;
      exp = 24'h0;
      total++; txn++;
      $display("txn %0d reset sw=%b out=%h exp=%h", txn, sw, output_1, exp);
      if (output_1 !== exp) begin
        bad++;
        $display("FAIL reset_zero: got %h want %h", output_1, exp);
      end
    end
    n_rst = 1'b0;
  endtask

  // Directed vectors: fixed windows, kernel code and expected output.
  task automatic test_directed();
    logic [23:0] exp;
    for (int t = 0; t < 8; t++) begin
      clear_windows();
      case (t)
        0: begin for (int k = 0; k < 9; k++) win[k] = 24'h102030; sw = 4'b0100; exp = 24'h102030; end
        1: begin win[0] = 24'hFFFFFF; win[3] = 24'hFFFFFF; win[6] = 24'hFFFFFF; sw = 4'b0101; exp = 24'hFFFFFF; end
        2: begin win[2] = 24'hFFFFFF; win[5] = 24'hFFFFFF; win[8] = 24'hFFFFFF; sw = 4'b0101; exp = 24'hFFFFFF; end
        3: begin win[4] = 24'h101010; sw = 4'b1100; exp = 24'h040404; end
        4: begin win[4] = 24'h101010; sw = 4'b0100; exp = 24'h010101; end
        5: begin win[6] = 24'h000010; win[8] = 24'h000030; sw = 4'b0111; exp = 24'h000020; end
        6: begin win[4] = 24'hABCDEF; sw = 4'b0000; exp = 24'hABCDEF; end
        default: begin for (int k = 0; k < 9; k++) win[k] = 24'hFFFFFF; sw = 4'b1100; exp = 24'hFFFFFF; end
      endcase
      @(posedge clk); #1;
      total++; txn++;
      $display("txn %0d directed%0d sw=%b out=%h exp=%h", txn, t, sw, output_1, exp);
      if (output_1 !== exp) begin
        bad++;
        $display("FAIL directed%0d: got %h want %h", t, output_1, exp);
      end
    end
  endtask

  // Random windows on every kernel code, including the codes that fall back to pass-through.
  task automatic test_random();
    logic [23:0] exp;
    logic [3:0] codes [6];
    codes[0] = 4'b0100; codes[1] = 4'b0101; codes[2] = 4'b0110;
    codes[3] = 4'b0111; codes[4] = 4'b1100; codes[5] = 4'b0000;
    for (int i = 0; i < 120; i++) begin
      random_windows();
      if (i % 2 == 0) sw = codes[$urandom_range(5)];
      else            sw = 4'($urandom);
      exp = model(win, sw);
      @(posedge clk); #1;
      total++; txn++;
      $display("txn %0d random sw=%b out=%h exp=%h", txn, sw, output_1, exp);
      if (output_1 !== exp) begin
        bad++;
        $display("FAIL random: sw=%b got %h want %h", sw, output_1, exp);
      end
    end
  endtask

  // The kernel changes every cycle with the windows held fixed. Each change
  // must take effect on the very next edge.
  task automatic test_back_to_back();
    logic [23:0] exp;
    random_windows();
    for (int i = 0; i < 32; i++) begin
      sw = 4'(i);
      exp = model(win, sw);
      @(posedge clk); #1;
      total++; txn++;
      $display("txn %0d b2b sw=%b out=%h exp=%h", txn, sw, output_1, exp);
      if (output_1 !== exp) begin
        bad++;
        $display("FAIL back_to_back: sw=%b got %h want %h", sw, output_1, exp);
      end
    end
  endtask

  // Reset in the middle of the stream, then recovery on the first edge after release.
  task automatic test_midstream_reset();
    logic [23:0] exp;
    clear_windows();
    random_windows();
    win[4] = 24'h123456;
    sw = 4'b0110;
    @(posedge clk); #1;
    exp = 24'h123456;
    total++; txn++;
    $display("txn %0d pre_reset out=%h exp=%h", txn, output_1, exp);
    if (output_1 !== exp) begin
      bad++;
      $display("FAIL pre_reset: got %h want %h", output_1, exp);
    end
    n_rst = 1'b1;
    @(posedge clk); #1;
    exp = 24'h0;
    total++; txn++;
    $display("txn %0d mid_reset out=%h exp=%h", txn, output_1, exp);
    if (output_1 !== exp) begin
      bad++;
      $display("FAIL mid_reset: got %h want %h", output_1, exp);
    end
    n_rst = 1'b0;
    @(posedge clk); #1;
    exp = 24'h123456;
    total++; txn++;
    $display("txn %0d post_reset out=%h exp=%h", txn, output_1, exp);
    if (output_1 !== exp) begin
      bad++;
      $display("FAIL post_reset: got %h want %h", output_1, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    txn   = 0;
    n_rst = 1'b1;
    sw    = 4'b0000;
    for (int k = 0; k < 9; k++) win[k] = 24'h0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_pixel_filter.md
MULTI_PIXEL_FILTER -- requirements
Module: multi_pixel_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 24, pixel width: three 8-bit channels packed {R[23:16], B[15:8], G[7:0]}.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-high: asserted when n_rst=1, sampled only on rising clk.
REQ-004 window_0..window_8  input  DATA_WIDTH each  3x3 neighbourhood, row-major: window_0..2 top row (left to right), window_3..5 middle, window_6..8 bottom; window_4 is centre.
REQ-005 sw  input  4  kernel select.
REQ-006 output_1  output  DATA_WIDTH  registered filtered pixel.

Function
REQ-007 Each channel (R, B, G) SHALL be processed independently with identical arithmetic; no cross-channel terms.
REQ-008 output_1 SHALL be registered with latency exactly 1 clk: value at edge N reflects window_* and sw sampled at edge N.
REQ-009 sw=4'b0100 box blur: S = sum of all 9 channel values (12-bit unsigned); out = floor(S/9), range 0..255.
REQ-010 sw=4'b0101 Sobel-X: G = (w0 + 2*w3 + w6) - (w2 + 2*w5 + w8), signed, at least 11 bits; out = |G| >> 2 (max 1020>>2 = 255, no overflow).
REQ-011 sw=4'b0110 centre pass: out = window_4.
REQ-012 sw=4'b0111 horizontal difference: out = |w6 - w8|, 8-bit, no wrap.
REQ-013 sw=4'b1100 Gaussian: S = (w0 + 2*w1 + w2 + 2*w3 + 4*w4 + 2*w5 + w6 + 2*w7 + w8), 12-bit; out = S >> 4 (floor), max 255.
REQ-014 Any other sw value SHALL output window_4 unchanged (default pass-through).
REQ-015 Intermediate sums SHALL be wide enough that no modular wrap occurs; all truncation is by explicit right shift or floor division.
REQ-016 A sw change SHALL take effect on the next clk edge, with no extra transition cycle and no glitch state.
REQ-017 The block SHALL be purely feed-forward: no state other than the output register.

Reset
REQ-018 While n_rst=1 at a rising edge, output_1 SHALL load 0 regardless of sw and window inputs.
REQ-019 Reset mid-stream: output_1 SHALL be 0 on the edge where reset is sampled.
REQ-020 On the first edge after n_rst returns to 0, output_1 SHALL reflect the inputs then present, per REQ-008.

Verification
REQ-021 All windows 0x102030, sw=0100 -> output_1 = 0x102030 one cycle later.
REQ-022 window_0/3/6 = 0xFFFFFF, others 0, sw=0101 -> 0xFFFFFF; mirrored (window_2/5/8 = 0xFFFFFF) -> 0xFFFFFF (magnitude).
REQ-023 window_4 = 0x101010, others 0, sw=1100 -> 0x040404; same inputs, sw=0100 -> 0x010101.
REQ-024 window_6 = 0x000010, window_8 = 0x000030, sw=0111 -> 0x000020; sw=0000 with window_4 = 0xABCDEF -> 0xABCDEF.
REQ-025 Drive sw=0110, window_4 = 0x123456, assert n_rst for one edge -> output_1 = 0; deassert -> 0x123456 on next edge.
